puf_ecc_sequencer: RTL
======================

PUF_ECC_SEQUENCER -- requirements
Module: puf_ecc_sequencer

Interface
REQ-001 SHALL have parameter SIG_W, default `IPID_WIDTH; PUF signature width, a multiple of 16.
REQ-002 SHALL have parameter N, default `IPID_N; number of IP requesters / IPID slots, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 64; maximum number of WAIT cycles before abort.
REQ-004 Port clk, input, 1: clock; all logic on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port req_valid, input, N: bit i is requester i's request, held until its rsp_valid pulse.
REQ-007 Port req_op, input, N: bit i is requester i's operation; 0 = provision, 1 = correct.
REQ-008 Port req_sig, input, N*SIG_W: slice i is requester i's raw PUF signature.
REQ-009 Port rsp_valid, output, N: one-hot, single-cycle completion pulse to the served requester.
REQ-010 Port rsp_sig, output, SIG_W: corrected signature; 0 for provision or error.
REQ-011 Port rsp_err, output, 1: error flag, qualified by any rsp_valid bit.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port provisioned, output, N: bit i set once slot i has been successfully provisioned.
REQ-014 Port ecc_instruction, output, 2: command to the ECC block; 00 idle, 01 provision, 10 correct.
REQ-015 Port ecc_puf_in, output, SIG_W: signature driven to the ECC block.
REQ-016 Port ecc_puf_in_valid, output, 1: qualifies ecc_puf_in for provisioning.
REQ-017 Port ecc_ipid_number, output, $clog2(N): slot index driven to the ECC block.
REQ-018 Port ecc_puf_out, input, SIG_W: corrected signature returned by the ECC block.
REQ-019 Port ecc_puf_out_valid, input, 1: correction result valid.
REQ-020 Port ecc_S_c, input, 1: parity storage complete.

Function
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RELEASE -> RESPOND -> IDLE; all outputs SHALL be registered.
REQ-022 IDLE, any req_valid high: SHALL grant round-robin, searching upward from (last_grant+1) mod N with wrap-around, then latch winner index, op and sig slice, and go to ISSUE.
REQ-023 IDLE, winner op = correct and provisioned[winner] = 0: SHALL skip the ECC block and go directly to RESPOND with rsp_err = 1 and rsp_sig = 0.
REQ-024 ISSUE: SHALL drive ecc_instruction = 01 (provision) or 10 (correct), ecc_ipid_number = winner, ecc_puf_in = latched sig and ecc_puf_in_valid = 1 (provision only), then go to WAIT.
REQ-025 WAIT: SHALL hold all ECC outputs stable and increment a timeout counter every cycle.
REQ-026 WAIT completion: ecc_S_c = 1 (provision) or ecc_puf_out_valid = 1 (correct) SHALL move the FSM to RELEASE; on correct, ecc_puf_out SHALL be captured that same edge.
REQ-027 WAIT timeout: reaching TIMEOUT cycles without completion SHALL move the FSM to RELEASE with the error flag set.
REQ-028 If completion and timeout coincide in the same cycle, completion SHALL win.
REQ-029 RELEASE, one cycle: SHALL drive ecc_instruction = 00, keep ecc_puf_in, ecc_ipid_number and ecc_puf_in_valid unchanged (provision needs valid high to exit), then go to RESPOND.
REQ-030 RESPOND, one cycle: SHALL pulse rsp_valid[winner], drive rsp_sig / rsp_err, drop ecc_puf_in_valid, and clear the counter.
REQ-031 RESPOND: SHALL set provisioned[winner] on a successful provision, update last_grant = winner, and return to IDLE.
REQ-032 Re-provisioning an already provisioned slot SHALL be permitted; the bit stays set.
REQ-033 A req_valid drop or a req_sig change after grant SHALL NOT affect the operation in flight.
REQ-034 Back-to-back requests: the minimum spacing between ISSUE cycles SHALL be 5 clocks.
REQ-035 Non-winning requesters SHALL see no rsp_valid until they are served; no requester SHALL starve.

Reset
REQ-036 rst_n low SHALL asynchronously force: state IDLE; all outputs 0; ecc_instruction = 00; provisioned = 0; last_grant = N-1 (so requester 0 has first priority); counter = 0.
REQ-037 Reset mid-operation SHALL abort the operation with no rsp_valid pulse; provisioned history SHALL be lost.

Verification
REQ-038 Reset, then req_valid[0] = 1, op = provision, sig = 0x1234..., ECC model returns S_c 1 cycle later -> ISSUE drives instr 01, ipid 0; rsp_valid = 0x1, rsp_err = 0; provisioned[0] = 1.
REQ-039 Slot 0 provisioned, correct request with 1 flipped bit per 16-bit word, model returns the true signature -> instr 10; rsp_sig equals the stored signature; rsp_err = 0.
REQ-040 Correct request on unprovisioned slot 2 -> ecc_instruction never leaves 00; rsp_valid = 0x4, rsp_err = 1, rsp_sig = 0.
REQ-041 All N requesters asserted continuously -> grants in order 0, 1, ..., N-1, 0, with each response exactly 5 cycles apart.
REQ-042 ECC model never completes, TIMEOUT = 64 -> RELEASE after 64 WAIT cycles; rsp_err = 1; provisioned unchanged.
REQ-043 rst_n pulsed during WAIT -> all outputs 0 immediately; no rsp_valid; the next request is serviced normally.

Source files
------------

// File: rtl/puf_ecc_sequencer.sv
// Arbitrates N PUF requesters round-robin and sequences provision/correct
// commands through a shared ECC block, returning one registered response each.
`ifndef IPID_WIDTH
`define IPID_WIDTH 32
`endif
`ifndef IPID_N
`define IPID_N 4
`endif

module puf_ecc_sequencer #(
  parameter int SIG_W   = `IPID_WIDTH,
  parameter int N       = `IPID_N,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_op,
  input  logic [N*SIG_W-1:0]   req_sig,
  output logic [N-1:0]         rsp_valid,
  output logic [SIG_W-1:0]     rsp_sig,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [N-1:0]         provisioned,
  output logic [1:0]           ecc_instruction,
  output logic [SIG_W-1:0]     ecc_puf_in,
  output logic                 ecc_puf_in_valid,
  output logic [$clog2(N)-1:0] ecc_ipid_number,
  input  logic [SIG_W-1:0]     ecc_puf_out,
  input  logic                 ecc_puf_out_valid,
  input  logic                 ecc_S_c
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE, S_RESPOND} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     win, win_nx, last, last_nx;
  logic              op, op_nx, err, err_nx;
  logic [SIG_W-1:0]  sig, sig_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [N-1:0]      rsp_valid_nx, prov_nx;
  logic [SIG_W-1:0]  rsp_sig_nx, puf_in_nx;
  logic              rsp_err_nx, pvalid_nx, done;
  logic [1:0]        instr_nx;
  logic [IW-1:0]     ipid_nx, grant_idx, cand;
  logic              grant_hit;

  // Walk offsets from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    grant_hit = |req_valid;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = N; k > 0; k--) begin
      cand = IW'((32'(last) + k) % N);
      if (req_valid[cand]) grant_idx = cand;
    end
  end

  always_comb begin
    state_nx     = state;
    win_nx       = win;
    last_nx      = last;
    op_nx        = op;
    sig_nx       = sig;
    err_nx       = err;
    cnt_nx       = cnt;
    instr_nx     = ecc_instruction;
    puf_in_nx    = ecc_puf_in;
    pvalid_nx    = ecc_puf_in_valid;
    ipid_nx      = ecc_ipid_number;
    prov_nx      = provisioned;
    rsp_valid_nx = '0;
    rsp_sig_nx   = '0;
    rsp_err_nx   = 1'b0;
    done         = op ? ecc_puf_out_valid : ecc_S_c;
    case (state)
      S_IDLE: begin
        if (grant_hit) begin
          win_nx = grant_idx;
          op_nx  = req_op[grant_idx];
          sig_nx = req_sig[grant_idx*SIG_W +: SIG_W];
          err_nx = 1'b0;
          if (req_op[grant_idx] && !provisioned[grant_idx]) begin
            state_nx                = S_RESPOND;
            err_nx                  = 1'b1;
            rsp_valid_nx[grant_idx] = 1'b1;
            rsp_err_nx              = 1'b1;
          end else begin
            state_nx  = S_ISSUE;
            instr_nx  = req_op[grant_idx] ? 2'b10 : 2'b01;
            ipid_nx   = grant_idx;
            puf_in_nx = req_sig[grant_idx*SIG_W +: SIG_W];
            pvalid_nx = !req_op[grant_idx];
          end
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        cnt_nx = cnt + 1'b1;
        // Completion is tested first so it wins over a coincident timeout.
        if (done) begin
          state_nx = S_RELEASE;
          instr_nx = 2'b00;
          if (op) sig_nx = ecc_puf_out;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nx = S_RELEASE;
          instr_nx = 2'b00;
          err_nx   = 1'b1;
        end
      end
      S_RELEASE: begin
        state_nx          = S_RESPOND;
        pvalid_nx         = 1'b0;
        rsp_valid_nx[win] = 1'b1;
        rsp_err_nx        = err;
        rsp_sig_nx        = (op && !err) ? sig : '0;
        if (!op && !err) prov_nx[win] = 1'b1;
      end
      S_RESPOND: begin
        state_nx = S_IDLE;
        last_nx  = win;
        cnt_nx   = '0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      win              <= '0;
      last             <= IW'(N - 1);
      op               <= 1'b0;
      sig              <= '0;
      err              <= 1'b0;
      cnt              <= '0;
      rsp_valid        <= '0;
      rsp_sig          <= '0;
      rsp_err          <= 1'b0;
      busy             <= 1'b0;
      provisioned      <= '0;
      ecc_instruction  <= '0;
      ecc_puf_in       <= '0;
      ecc_puf_in_valid <= 1'b0;
      ecc_ipid_number  <= '0;
    end else begin
      state            <= state_nx;
      win              <= win_nx;
      last             <= last_nx;
      op               <= op_nx;
      sig              <= sig_nx;
      err              <= err_nx;
      cnt              <= cnt_nx;
      rsp_valid        <= rsp_valid_nx;
      rsp_sig          <= rsp_sig_nx;
      rsp_err          <= rsp_err_nx;
      busy             <= (state_nx != S_IDLE);
      provisioned      <= prov_nx;
      ecc_instruction  <= instr_nx;
      ecc_puf_in       <= puf_in_nx;
      ecc_puf_in_valid <= pvalid_nx;
      ecc_ipid_number  <= ipid_nx;
    end
  end
endmodule
